// File: rtl/mano_timing_control_if.sv
// mano_timing_control_if
//   Bundles the signals between the timing/control stage and the rest of the
//   Mano datapath/memory.
//   master : timing/control side (takes IR contents, DR test and START;
//            drives sequence count, decodes and strobes)
//   slave  : datapath/memory side (the mirror image)
//   Signals:
//     IN_IR    instruction register contents
//     DR_ZERO  DR==0 after increment (ISZ skip test)
//     START    one-cycle pulse that clears HALT
//     t        sequence count
//     T        one-hot timing signals
//     D        one-hot opcode decode
//     I_FLAG   latched indirect bit
//     MEM_RD / MEM_WR / AR_LD / IR_LD / PC_INC / SC_CLR / HALT  strobes and status
interface mano_timing_control_if #(
    parameter int SC_W = 3
);
    logic [15:0]            IN_IR;
    logic                   DR_ZERO;
    logic                   START;
    logic [SC_W-1:0]        t;
    logic [(1<<SC_W)-1:0]   T;
    logic [7:0]             D;
    logic                   I_FLAG;
    logic                   MEM_RD;
    logic                   MEM_WR;
    logic                   AR_LD;
    logic                   IR_LD;
    logic                   PC_INC;
    logic                   SC_CLR;
    logic                   HALT;

    modport master (
        input  IN_IR, DR_ZERO, START,
        output t, T, D, I_FLAG, MEM_RD, MEM_WR, AR_LD, IR_LD, PC_INC, SC_CLR, HALT
    );

    modport slave (
        output IN_IR, DR_ZERO, START,
        input  t, T, D, I_FLAG, MEM_RD, MEM_WR, AR_LD, IR_LD, PC_INC, SC_CLR, HALT
    );
endinterface

// File: rtl/mano_timing_control.sv
// mano_timing_control
//   Timing and control stage of the Mano basic computer. Runs the sequence
//   counter, decodes IR into D0..D7 and I, and issues per-cycle memory and
//   register strobes. All strobes are combinational from registered state and
//   IN_IR, so they are settled before the memory stage samples on negedge.
//   Ports:
//     CLK    system clock, state updates on posedge
//     RST_N  asynchronous active-low reset
//     bus    mano_timing_control_if.master (see interface for signal list)
//
//   Mode FSM (the sequence counter t runs inside ST_RUN)
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | executing; t advances each cycle, cleared by SC_CLR
//   ST_HALT | halted; t held at 0, all strobes low, START returns to ST_RUN
module mano_timing_control #(
    parameter int SC_W    = 3,
    parameter int HLT_BIT = 0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    mano_timing_control_if.master  bus
);

    localparam int N_T = 1 << SC_W;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } mode_t;

    mode_t            mode_q, mode_d;
    logic [SC_W-1:0]  t_q, t_d;
    logic             i_q, i_d;

    logic [N_T-1:0]   t_dec;
    logic [7:0]       d_dec;
    logic             mem_rd, mem_wr, ar_ld, ir_ld, pc_inc, sc_clr;

    // Only the opcode, indirect and HLT select bits of IR matter here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^bus.IN_IR;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q <= ST_RUN;
            t_q    <= '0;
            i_q    <= 1'b0;
        end else begin
            mode_q <= mode_d;
            t_q    <= t_d;
            i_q    <= i_d;
        end
    end

    always_comb begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        ar_ld  = 1'b0;
        ir_ld  = 1'b0;
        pc_inc = 1'b0;
        sc_clr = 1'b0;
        mode_d = mode_q;
        t_d    = t_q;
        i_d    = i_q;

        t_dec        = '0;
        t_dec[t_q]   = 1'b1;
        d_dec        = '0;
        d_dec[bus.IN_IR[14:12]] = 1'b1;

        if (mode_q == ST_HALT) begin
            t_d = '0;
            if (bus.START) begin
                mode_d = ST_RUN;
            end
        end else begin
            case (t_q)
                SC_W'(0): begin
                    ar_ld = 1'b1;
                end
                SC_W'(1): begin
                    mem_rd = 1'b1;
                    ir_ld  = 1'b1;
                    pc_inc = 1'b1;
                end
                SC_W'(2): begin
                    ar_ld = 1'b1;
                    i_d   = bus.IN_IR[15];
                end
                SC_W'(3): begin
                    if (d_dec[7]) begin
                        sc_clr = 1'b1;
                        // HLT lives only in the register-reference group (I=0).
                        if (!i_q && bus.IN_IR[HLT_BIT]) begin
                            mode_d = ST_HALT;
                        end
                    end else if (i_q) begin
                        mem_rd = 1'b1;
                        ar_ld  = 1'b1;
                    end
                end
                SC_W'(4): begin
                    if (d_dec[0] || d_dec[1] || d_dec[2] || d_dec[6]) begin
                        mem_rd = 1'b1;
                    end else if (d_dec[3]) begin
                        mem_wr = 1'b1;
                        sc_clr = 1'b1;
                    end else if (d_dec[5]) begin
                        mem_wr = 1'b1;
                    end else begin
                        // BUN, plus recovery if a D7 ever reaches T4.
                        sc_clr = 1'b1;
                    end
                end
                SC_W'(5): begin
                    if (!d_dec[6]) begin
                        sc_clr = 1'b1;
                    end
                end
                SC_W'(6): begin
                    sc_clr = 1'b1;
                    if (d_dec[6]) begin
                        mem_wr = 1'b1;
                        pc_inc = bus.DR_ZERO;
                    end
                end
                default: begin
                    // T7 and beyond are unreachable in a legal flow; recover to T0.
                    sc_clr = 1'b1;
                end
            endcase

            if (sc_clr) begin
                t_d = '0;
            end else begin
                t_d = t_q + 1'b1;
            end
        end
    end

    // Strobes are forced low while reset is asserted, not just after it.
    assign bus.t      = t_q;
    assign bus.T      = t_dec;
    assign bus.D      = d_dec;
    assign bus.I_FLAG = i_q;
    assign bus.HALT   = (mode_q == ST_HALT);
    assign bus.MEM_RD = RST_N & mem_rd;
    assign bus.MEM_WR = RST_N & mem_wr;
    assign bus.AR_LD  = RST_N & ar_ld;
    assign bus.IR_LD  = RST_N & ir_ld;
    assign bus.PC_INC = RST_N & pc_inc;
    assign bus.SC_CLR = RST_N & sc_clr;

endmodule

// File: tb/tb_mano_timing_control.sv
// tb_mano_timing_control
//   Directed-vector bench for mano_timing_control. Each task runs one
//   instruction scenario cycle by cycle against a hand-written table of
//   {t, MEM_RD, MEM_WR, AR_LD, IR_LD, PC_INC, SC_CLR, HALT}. A negedge
//   monitor checks the always-true properties (no RD+WR, T and D one-hot).
module tb_mano_timing_control;

    logic CLK;
    logic RST_N;

    mano_timing_control_if #(.SC_W(3)) bus ();

    mano_timing_control #(.SC_W(3), .HLT_BIT(0)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_RD   = 7'b1000000;
    localparam logic [6:0] S_WR   = 7'b0100000;
    localparam logic [6:0] S_AR   = 7'b0010000;
    localparam logic [6:0] S_IR   = 7'b0001000;
    localparam logic [6:0] S_PC   = 7'b0000100;
    localparam logic [6:0] S_CLR  = 7'b0000010;
    localparam logic [6:0] S_HLT  = 7'b0000001;
    localparam logic [6:0] S_FET  = S_RD | S_IR | S_PC;

    logic [9:0] obs;
    assign obs = {bus.t, bus.MEM_RD, bus.MEM_WR, bus.AR_LD, bus.IR_LD,
                  bus.PC_INC, bus.SC_CLR, bus.HALT};

    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            n_vec++;
            if ((bus.MEM_RD & bus.MEM_WR) !== 1'b0) begin
                n_err++;
                $display("FAIL rd_wr_excl t=%0d: RD=%b WR=%b, want not both 1",
                         bus.t, bus.MEM_RD, bus.MEM_WR);
            end
            n_vec++;
            if (bus.T !== (8'd1 << bus.t)) begin
                n_err++;
                $display("FAIL t_onehot: T=%b for t=%0d", bus.T, bus.t);
            end
            n_vec++;
            if (bus.D !== (8'd1 << bus.IN_IR[14:12])) begin
                n_err++;
                $display("FAIL d_decode: D=%b for IR[14:12]=%0d", bus.D, bus.IN_IR[14:12]);
            end
        end
    end

    task automatic test_reset();
        RST_N       = 1'b0;
        bus.START   = 1'b0;
        bus.DR_ZERO = 1'b0;
        bus.IN_IR   = 16'h0000;
        repeat (2) @(posedge CLK);
        #1;
        n_vec++;
        if (obs !== 10'd0) begin
            n_err++;
            $display("FAIL reset_state: got %b want %b", obs, 10'd0);
        end
        n_vec++;
        if (bus.I_FLAG !== 1'b0) begin
            n_err++;
            $display("FAIL reset_iflag: got %b want 0", bus.I_FLAG);
        end
        n_vec++;
        if (bus.T !== 8'h01) begin
            n_err++;
            $display("FAIL reset_T: got %b want 00000001", bus.T);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_lda();
        logic [9:0] exp [6];
        exp = '{ {3'd0, S_AR}, {3'd1, S_FET}, {3'd2, S_AR},
                 {3'd3, S_NONE}, {3'd4, S_RD}, {3'd5, S_CLR} };
        bus.IN_IR = 16'h2123;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_vec++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL lda[%0d]: got %b want %b", i, obs, exp[i]);
            end
            if (i == 3) begin
                n_vec++;
                if (bus.I_FLAG !== 1'b0) begin
                    n_err++;
                    $display("FAIL lda_iflag: got %b want 0", bus.I_FLAG);
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_sta_indirect();
        logic [9:0] exp [5];
        exp = '{ {3'd0, S_AR}, {3'd1, S_FET}, {3'd2, S_AR},
                 {3'd3, S_RD | S_AR}, {3'd4, S_WR | S_CLR} };
        bus.IN_IR = 16'hB050;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL sta_ind[%0d]: got %b want %b", i, obs, exp[i]);
            end
            if (i == 3) begin
                n_vec++;
                if (bus.I_FLAG !== 1'b1) begin
                    n_err++;
                    $display("FAIL sta_iflag: got %b want 1", bus.I_FLAG);
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_add_indirect();
        logic [9:0] exp [6];
        exp = '{ {3'd0, S_AR}, {3'd1, S_FET}, {3'd2, S_AR},
                 {3'd3, S_RD | S_AR}, {3'd4, S_RD}, {3'd5, S_CLR} };
        bus.IN_IR = 16'h9123;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_vec++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL add_ind[%0d]: got %b want %b", i, obs, exp[i]);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_bsa();
        logic [9:0] exp [6];
        exp = '{ {3'd0, S_AR}, {3'd1, S_FET}, {3'd2, S_AR},
                 {3'd3, S_NONE}, {3'd4, S_WR}, {3'd5, S_CLR} };
        bus.IN_IR = 16'h5010;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_vec++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL bsa[%0d]: got %b want %b", i, obs, exp[i]);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_isz_skip();
        logic [9:0] exp [7];
        exp = '{ {3'd0, S_AR}, {3'd1, S_FET}, {3'd2, S_AR}, {3'd3, S_NONE},
                 {3'd4, S_RD}, {3'd5, S_NONE}, {3'd6, S_WR | S_PC | S_CLR} };
        bus.IN_IR   = 16'h6010;
        bus.DR_ZERO = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            n_vec++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL isz_skip[%0d]: got %b want %b", i, obs, exp[i]);
            end
            @(posedge CLK);
            #1;
        end
        bus.DR_ZERO = 1'b0;
    endtask

    task automatic test_reg_ref();
        logic [9:0] exp [4];
        logic [15:0] irs [2];
        exp = '{ {3'd0, S_AR}, {3'd1, S_FET}, {3'd2, S_AR}, {3'd3, S_CLR} };
        irs = '{ 16'h7002, 16'hF001 };
        for (int k = 0; k < 2; k++) begin
            bus.IN_IR = irs[k];
            for (int i = 0; i < 4; i++) begin
                #1;
                n_vec++;
                if (obs !== exp[i]) begin
                    n_err++;
                    $display("FAIL reg_ref ir=%h [%0d]: got %b want %b", irs[k], i, obs, exp[i]);
                end
                @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic test_halt_start();
        logic [9:0] exp [4];
        exp = '{ {3'd0, S_AR}, {3'd1, S_FET}, {3'd2, S_AR}, {3'd3, S_CLR} };
        bus.IN_IR = 16'h7001;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL hlt[%0d]: got %b want %b", i, obs, exp[i]);
            end
            @(posedge CLK);
            #1;
        end
        for (int i = 0; i < 10; i++) begin
            #1;
            n_vec++;
            if (obs !== {3'd0, S_HLT}) begin
                n_err++;
                $display("FAIL halted[%0d]: got %b want %b", i, obs, {3'd0, S_HLT});
            end
            @(posedge CLK);
            #1;
        end
        bus.START = 1'b1;
        #1;
        n_vec++;
        if (obs !== {3'd0, S_HLT}) begin
            n_err++;
            $display("FAIL start_same_cycle: got %b want %b", obs, {3'd0, S_HLT});
        end
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
    endtask

    task automatic test_bun_start_running();
        logic [9:0] exp [5];
        exp = '{ {3'd0, S_AR}, {3'd1, S_FET}, {3'd2, S_AR},
                 {3'd3, S_NONE}, {3'd4, S_CLR} };
        bus.IN_IR = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            bus.START = (i == 2);
            #1;
            n_vec++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL bun[%0d]: got %b want %b", i, obs, exp[i]);
            end
            @(posedge CLK);
            #1;
        end
        bus.START = 1'b0;
    endtask

    task automatic test_reset_mid_isz();
        logic [9:0] exp [4];
        logic [9:0] exp2 [8];
        exp  = '{ {3'd0, S_AR}, {3'd1, S_FET}, {3'd2, S_AR}, {3'd3, S_NONE} };
        exp2 = '{ {3'd0, S_AR}, {3'd1, S_FET}, {3'd2, S_AR}, {3'd3, S_NONE},
                  {3'd4, S_RD}, {3'd5, S_NONE}, {3'd6, S_WR | S_CLR}, {3'd0, S_AR} };
        bus.IN_IR   = 16'h6010;
        bus.DR_ZERO = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL isz_pre[%0d]: got %b want %b", i, obs, exp[i]);
            end
            @(posedge CLK);
            #1;
        end
        #1;
        n_vec++;
        if (obs !== {3'd4, S_RD}) begin
            n_err++;
            $display("FAIL isz_t4: got %b want %b", obs, {3'd4, S_RD});
        end
        RST_N = 1'b0;
        #1;
        n_vec++;
        if (obs !== 10'd0) begin
            n_err++;
            $display("FAIL mid_reset: got %b want %b", obs, 10'd0);
        end
        @(posedge CLK);
        #1;
        n_vec++;
        if (obs !== 10'd0) begin
            n_err++;
            $display("FAIL mid_reset_hold: got %b want %b", obs, 10'd0);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_vec++;
            if (obs !== exp2[i]) begin
                n_err++;
                $display("FAIL isz_noskip[%0d]: got %b want %b", i, obs, exp2[i]);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sta_indirect();
        test_add_indirect();
        test_bsa();
        test_isz_skip();
        test_reg_ref();
        test_halt_start();
        test_bun_start_running();
        test_reset_mid_isz();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
